// File: rtl/pipe_phy_status_responder.sv
// PIPE PHY status responder: models the PHY side of the PIPE handshake. It answers
// receiver-detect, powerdown and rate commands from the MAC with a one-cycle phystatus
// pulse after a per-command latency. It also holds phystatus high for a fixed time
// after reset.
//
// Ports:
//   clk_i              single clock
//   rst_i              synchronous active-high reset
//   phy_txdetectrx     receiver-detect request (rising edge)
//   phy_txelecidle     per-lane electrical idle
//   phy_powerdown      power state (P0..P2 encoding)
//   phy_rate           link rate
//   rx_present_i       per-lane far-end receiver present
//   phy_phystatus      per-lane completion pulse / reset-hold level
//   phy_rxstatus       3 bits per lane; 3'b011 reports a detected receiver
//   phy_phystatus_rst  high while in reset or during reset hold
//   busy_o             a command or the reset hold is in progress
//   cmd_err_o          one-cycle pulse when an illegal command is seen
module pipe_phy_status_responder #(
  parameter int unsigned MAX_NUM_LANES   = 1,
  parameter int unsigned DETECT_LATENCY  = 16,
  parameter int unsigned PD_LATENCY      = 8,
  parameter int unsigned RATE_LATENCY    = 32,
  parameter int unsigned RST_HOLD_CYCLES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         phy_txdetectrx,
  input  logic [MAX_NUM_LANES-1:0]     phy_txelecidle,
  input  logic [1:0]                   phy_powerdown,
  input  logic [2:0]                   phy_rate,
  input  logic [MAX_NUM_LANES-1:0]     rx_present_i,
  output logic [MAX_NUM_LANES-1:0]     phy_phystatus,
  output logic [3*MAX_NUM_LANES-1:0]   phy_rxstatus,
  output logic                         phy_phystatus_rst,
  output logic                         busy_o,
  output logic                         cmd_err_o
);

  typedef enum logic [2:0] {RST_HOLD, IDLE, DETECT, PD_WAIT, RATE_WAIT} state_e;

  // Counter loads are latency-1: the counter reaches zero in the completion cycle.
  localparam logic [7:0] DetLoad  = 8'(DETECT_LATENCY - 1);
  localparam logic [7:0] PdLoad   = 8'(PD_LATENCY - 1);
  localparam logic [7:0] RateLoad = 8'(RATE_LATENCY - 1);
  localparam logic [7:0] HoldLoad = 8'(RST_HOLD_CYCLES - 1);

  state_e     r_state, w_state_d;
  logic [7:0] r_cnt, w_cnt_d;
  logic [1:0] r_pd_q, w_pd_d;
  logic [2:0] r_rate_q, w_rate_d;
  logic       r_det_prev;
  logic       r_det_pend, w_pend_d;

  logic w_det_rise, w_det_req, w_det_ok, w_rate_cmd, w_rate_ok, w_pd_cmd;
  logic w_done, w_err, w_hold;

  assign w_det_rise = phy_txdetectrx & ~r_det_prev;
  assign w_det_req  = w_det_rise | r_det_pend;
  assign w_det_ok   = (phy_powerdown == 2'b10) && (&phy_txelecidle);
  assign w_rate_cmd = (phy_rate != r_rate_q);
  assign w_rate_ok  = ~phy_powerdown[1];
  assign w_pd_cmd   = (phy_powerdown != r_pd_q);

  always_ff @(posedge clk_i) begin
    r_det_prev <= phy_txdetectrx;
    if (rst_i) begin
      r_state    <= RST_HOLD;
      r_cnt      <= HoldLoad;
      r_det_pend <= 1'b0;
      r_pd_q     <= phy_powerdown;
      r_rate_q   <= phy_rate;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_det_pend <= w_pend_d;
      r_pd_q     <= w_pd_d;
      r_rate_q   <= w_rate_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pd_d    = r_pd_q;
    w_rate_d  = r_rate_q;
    w_pend_d  = r_det_pend;
    w_done    = 1'b0;
    w_err     = 1'b0;
    unique case (r_state)
      RST_HOLD: begin
        // Track the inputs throughout the hold so IDLE starts with nothing pending.
        w_pd_d   = phy_powerdown;
        w_rate_d = phy_rate;
        w_pend_d = 1'b0;
        if (r_cnt == 8'd0) w_state_d = IDLE;
        else               w_cnt_d   = r_cnt - 8'd1;
      end
      IDLE: begin
        if (w_det_req) begin
          w_pend_d = 1'b0;
          if (w_det_ok) begin
            w_state_d = DETECT;
            w_cnt_d   = DetLoad;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_rate_cmd) begin
          // An illegal rate is still absorbed so it is not retried forever.
          w_rate_d = phy_rate;
          if (w_rate_ok) begin
            w_state_d = RATE_WAIT;
            w_cnt_d   = RateLoad;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_pd_cmd) begin
          w_pd_d    = phy_powerdown;
          w_state_d = PD_WAIT;
          w_cnt_d   = PdLoad;
        end
      end
      DETECT, PD_WAIT, RATE_WAIT: begin
        if (w_det_rise) w_pend_d = 1'b1;
        if (r_cnt == 8'd0) begin
          w_done    = 1'b1;
          w_state_d = IDLE;
        end else begin
          w_cnt_d = r_cnt - 8'd1;
        end
      end
      default: w_state_d = RST_HOLD;
    endcase
  end

  // Reset overrides everything combinationally so an in-flight completion is suppressed.
  assign w_hold            = rst_i | (r_state == RST_HOLD);
  assign phy_phystatus     = w_hold ? {MAX_NUM_LANES{1'b1}} : {MAX_NUM_LANES{w_done}};
  assign phy_phystatus_rst = w_hold;
  assign busy_o            = rst_i | (r_state != IDLE);
  assign cmd_err_o         = w_err & ~rst_i;

  always_comb begin
    phy_rxstatus = '0;
    for (int unsigned i = 0; i < MAX_NUM_LANES; i++) begin
      if (!rst_i && (r_state == DETECT) && w_done && rx_present_i[i]) begin
        phy_rxstatus[i*3 +: 3] = 3'b011;
      end
    end
  end

endmodule

// File: tb/tb_pipe_phy_status_responder.sv
module tb_pipe_phy_status_responder;

  localparam int unsigned Lanes = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               txdet;
  logic [Lanes-1:0]   elecidle;
  logic [1:0]         pd;
  logic [2:0]         rate;
  logic [Lanes-1:0]   rxp;
  logic [Lanes-1:0]   phystatus;
  logic [3*Lanes-1:0] rxstatus;
  logic               phystatus_rst;
  logic               busy;
  logic               cmd_err;

  pipe_phy_status_responder #(
    .MAX_NUM_LANES  (Lanes),
    .DETECT_LATENCY (16),
    .PD_LATENCY     (8),
    .RATE_LATENCY   (32),
    .RST_HOLD_CYCLES(4)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .phy_txdetectrx   (txdet),
    .phy_txelecidle   (elecidle),
    .phy_powerdown    (pd),
    .phy_rate         (rate),
    .rx_present_i     (rxp),
    .phy_phystatus    (phystatus),
    .phy_rxstatus     (rxstatus),
    .phy_phystatus_rst(phystatus_rst),
    .busy_o           (busy),
    .cmd_err_o        (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int               cyc;
    logic [3*Lanes-1:0] rx;
  } exp_t;

  exp_t pulse_q[$];
  int   err_q[$];
  exp_t e;
  int   ecyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic push_pulse(input int c, input logic [3*Lanes-1:0] rx);
    exp_t x;
    x.cyc = c;
    x.rx  = rx;
    pulse_q.push_back(x);
  endtask

  // Expects rst already high; checks the reset level, then the post-release hold.
  task automatic reset_seq();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_phystatus", phystatus, 2'b11);
      check("rst_phystatus_rst", phystatus_rst, 1);
      check("rst_busy", busy, 1);
      check("rst_rxstatus", rxstatus, 0);
      check("rst_cmd_err", cmd_err, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_phystatus", phystatus, 2'b11);
      check("hold_phystatus_rst", phystatus_rst, 1);
      check("hold_busy", busy, 1);
    end
    @(negedge clk);
    check("idle_phystatus", phystatus, 0);
    check("idle_phystatus_rst", phystatus_rst, 0);
    check("idle_busy", busy, 0);
    mon_en = 1'b1;
  endtask

  task automatic set_pd(input logic [1:0] v);
    tick();
    pd = v;
    push_pulse(cyc + 8, '0);
    wait_cycles(12);
  endtask

  task automatic do_detect(input logic [Lanes-1:0] present, input logic [3*Lanes-1:0] exp_rx);
    tick();
    rxp   = present;
    txdet = 1'b1;
    push_pulse(cyc + 16, exp_rx);
    wait_cycles(20);
    tick();
    txdet = 1'b0;
    wait_cycles(2);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (phystatus !== '0) begin
        if (pulse_q.size() == 0) begin
          check("spurious_pulse", phystatus, 0);
        end else begin
          e = pulse_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_lanes", phystatus, 2'b11);
          check("pulse_rxstatus", rxstatus, e.rx);
        end
      end else begin
        check("rxstatus_quiet", rxstatus, 0);
      end
      if (cmd_err === 1'b1) begin
        if (err_q.size() == 0) begin
          check("spurious_err", cmd_err, 0);
        end else begin
          ecyc = err_q.pop_front();
          check("err_cycle", cyc, ecyc);
        end
      end
      check("phystatus_rst_low", phystatus_rst, 0);
    end
  end

  int n;

  initial begin
    rst      = 1'b1;
    txdet    = 1'b0;
    elecidle = '1;
    pd       = 2'b00;
    rate     = 3'd0;
    rxp      = '0;
    reset_seq();

    // Enter P1, then receiver detect with various far-end presence patterns.
    set_pd(2'b10);
    do_detect(2'b11, 6'b011_011);
    do_detect(2'b01, 6'b000_011);
    do_detect(2'b00, 6'b000_000);

    // Detect in P0 is illegal.
    set_pd(2'b00);
    tick();
    txdet = 1'b1;
    err_q.push_back(cyc);
    wait_cycles(20);
    tick();
    txdet = 1'b0;
    wait_cycles(3);

    // Detect in P1 with a lane not in electrical idle is illegal.
    set_pd(2'b10);
    tick();
    elecidle = 2'b01;
    txdet    = 1'b1;
    err_q.push_back(cyc);
    wait_cycles(20);
    tick();
    txdet    = 1'b0;
    elecidle = '1;
    wait_cycles(3);

    // Powerdown change and detect in the same cycle: detect first, then powerdown.
    set_pd(2'b00);
    tick();
    pd    = 2'b10;
    txdet = 1'b1;
    rxp   = 2'b10;
    n     = cyc;
    push_pulse(n + 16, 6'b011_000);
    push_pulse(n + 17 + 8, '0);
    wait_cycles(30);
    tick();
    txdet = 1'b0;
    wait_cycles(2);

    // Legal rate change in P0.
    set_pd(2'b00);
    tick();
    rate = 3'd1;
    push_pulse(cyc + 32, '0);
    tick();
    @(negedge clk);
    check("busy_rate_wait", busy, 1);
    wait_cycles(36);

    // Rate change in P1 is illegal and is absorbed without a pulse.
    set_pd(2'b10);
    tick();
    rate = 3'd2;
    err_q.push_back(cyc);
    wait_cycles(40);

    // Rate and powerdown in the same cycle: rate wins, powerdown follows.
    tick();
    rate = 3'd3;
    pd   = 2'b00;
    n    = cyc;
    push_pulse(n + 32, '0);
    push_pulse(n + 33 + 8, '0);
    wait_cycles(45);

    // Reset in the middle of a rate wait aborts it; the new rate is not replayed.
    tick();
    rate = 3'd4;
    wait_cycles(10);
    mon_en = 1'b0;
    rst    = 1'b1;
    reset_seq();
    wait_cycles(50);

    // Detect raised during a powerdown wait is held and serviced afterwards.
    tick();
    pd  = 2'b10;
    rxp = 2'b11;
    n   = cyc;
    push_pulse(n + 8, '0);
    wait_cycles(2);
    tick();
    txdet = 1'b1;
    push_pulse(n + 9 + 16, 6'b011_011);
    wait_cycles(30);
    tick();
    txdet = 1'b0;
    wait_cycles(5);

    check("pulses_outstanding", pulse_q.size(), 0);
    check("errs_outstanding", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_phy_status_responder.md
PIPE_PHY_STATUS_RESPONDER -- requirements
Module: pipe_phy_status_responder

Interface
REQ-001 The block SHALL have parameter MAX_NUM_LANES, default 1, the number of PIPE lanes modelled.
REQ-002 The block SHALL have parameter DETECT_LATENCY, default 16, the cycles from a detect request to its completion pulse (range 2..255).
REQ-003 The block SHALL have parameter PD_LATENCY, default 8, the cycles from a powerdown change to its completion pulse (range 2..255).
REQ-004 The block SHALL have parameter RATE_LATENCY, default 32, the cycles from a rate change to its completion pulse (range 2..255).
REQ-005 The block SHALL have parameter RST_HOLD_CYCLES, default 4, the cycles phystatus stays high after reset release (range 1..255).
REQ-006 The block SHALL have these ports: clk_i, input, 1, the single clock; rst_i, input, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have these ports: phy_txdetectrx, input, 1, MAC receiver-detect request; phy_txelecidle, input, MAX_NUM_LANES, MAC electrical idle per lane.
REQ-008 The block SHALL have these ports: phy_powerdown, input, 2, MAC power state; phy_rate, input, 3, MAC rate.
REQ-009 The block SHALL have port rx_present_i, input, MAX_NUM_LANES, far-end receiver present per lane (bench-driven).
REQ-010 The block SHALL have these ports: phy_phystatus, output, MAX_NUM_LANES; phy_rxstatus, output, 3*MAX_NUM_LANES, lane i at [i*3+:3]; phy_phystatus_rst, output, 1.
REQ-011 The block SHALL have these ports: busy_o, output, 1, command in progress; cmd_err_o, output, 1, one-cycle illegal-command pulse.

Function
REQ-012 The state machine SHALL have exactly these states: RST_HOLD, IDLE, DETECT, PD_WAIT, RATE_WAIT.
REQ-013 The block SHALL use one 8-bit down-counter shared by all wait states.
REQ-014 The block SHALL use registered copies pd_q and rate_q of the last accepted powerdown and rate values.
REQ-015 A detect request SHALL be a rising edge of phy_txdetectrx, compared against a registered copy of the previous cycle.
REQ-016 A detect request SHALL be accepted only when phy_powerdown==2'b10 (P1) and all phy_txelecidle bits are 1; otherwise cmd_err_o SHALL pulse for 1 cycle and the state SHALL stay IDLE.
REQ-017 A powerdown command SHALL be phy_powerdown!=pd_q; a rate command SHALL be phy_rate!=rate_q.
REQ-018 A rate command SHALL be accepted only when phy_powerdown is 2'b00 or 2'b01; otherwise cmd_err_o SHALL pulse, rate_q SHALL update, and no phystatus pulse SHALL occur.
REQ-019 If a command is first visible in IDLE at cycle N, phy_phystatus SHALL be high on all lanes for exactly cycle N+LATENCY, where LATENCY is the parameter for that command type.
REQ-020 The state SHALL return to IDLE at cycle N+LATENCY+1.
REQ-021 When more than one command is pending in IDLE in the same cycle, priority SHALL be detect > rate > powerdown.
REQ-022 A command that is not serviced SHALL remain pending, because its compare against pd_q/rate_q still differs.
REQ-023 A detect rising edge that occurs outside IDLE SHALL be latched in a pending flag and serviced on return to IDLE.
REQ-024 pd_q or rate_q SHALL be updated on the cycle its command is accepted.
REQ-025 A value change during PD_WAIT or RATE_WAIT SHALL be handled as a new command after return to IDLE.
REQ-026 During the DETECT completion cycle, lane i of phy_rxstatus SHALL be 3'b011 if rx_present_i[i] is 1, else 3'b000, with rx_present_i sampled in that cycle.
REQ-027 phy_rxstatus SHALL be 0 in all other cycles.
REQ-028 busy_o SHALL be 1 in DETECT, PD_WAIT, RATE_WAIT and RST_HOLD, and 0 in IDLE.
REQ-029 The block SHALL produce at most one phystatus pulse per accepted command and SHALL produce no pulse for an ignored command.

Reset
REQ-030 While rst_i=1: state=RST_HOLD, phy_phystatus all 1, phy_phystatus_rst=1, phy_rxstatus=0, busy_o=1, cmd_err_o=0, counter=RST_HOLD_CYCLES-1, pending detect cleared.
REQ-031 After rst_i falls, phy_phystatus and phy_phystatus_rst SHALL remain 1 for exactly RST_HOLD_CYCLES cycles, then go 0 as the state enters IDLE.
REQ-032 On the cycle of entry to IDLE from reset, pd_q, rate_q and the txdetectrx history SHALL load the current inputs, so no command pulse or error results.
REQ-033 rst_i asserted in any state SHALL abort the current command with no completion pulse and SHALL re-enter RST_HOLD on the next edge.

Verification
REQ-034 Bench: rst_i high 3 cycles then low, RST_HOLD_CYCLES=4 -> phystatus and phystatus_rst high through 4 cycles after release, then 0; no further pulses.
REQ-035 Bench: powerdown=2'b10, txelecidle=1, rx_present_i=1, txdetectrx 0->1 at cycle N -> phystatus high only at N+16 with rxstatus=3'b011; repeat with rx_present_i=0 -> rxstatus=3'b000.
REQ-036 Bench: txdetectrx rising while powerdown=2'b00 -> cmd_err_o pulses 1 cycle, no phystatus pulse.
REQ-037 Bench: powerdown 00->10 and txdetectrx rising in the same cycle N -> detect pulse at N+16, powerdown pulse at N+17+8.
REQ-038 Bench: rate change at cycle N with powerdown=00, rst_i asserted at N+10 -> no completion pulse; RST_HOLD sequence runs; after reset no pulse occurs for the already-changed rate.
